// File: rtl/icache_refill_responder.sv
// icache_refill_responder
// Memory-side responder for instruction-cache line refills. A request latches
// an aligned line base, reads LINE_WORDS words from the backing memory with up
// to MAX_OUTSTANDING reads in flight, buffers the returns, and replays the line
// as a single gap-free burst on resp_data/resp_ack.
//
// Optional build macro: ICACHE_REFILL_STATS_EN adds saturating stat_refills and
// stat_wait_cycles outputs. Without it neither the ports nor the counters exist.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for icache_ren; latches the aligned line base
// ST_FETCH  | issuing memory reads and capturing returns into line_buf
// ST_STREAM | presenting line_buf[0..LINE_WORDS-1], one word per cycle
// ST_DRAIN  | single ack-low cycle that separates consecutive lines

module icache_refill_responder #(
    parameter int LINE_WORDS      = 16,
    parameter int ADDR_W          = 21,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              cpu_clk,
    input  logic              reset_n,
    input  logic              icache_ren,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic [31:0]       resp_data,
    output logic              resp_ack,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_REFILL_STATS_EN
    ,
    output logic [31:0]       stat_refills,
    output logic [31:0]       stat_wait_cycles
`endif
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0]  LINE_CNT   = CNT_W'(LINE_WORDS);
    localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [OUT_W-1:0]  out_cnt;
    logic [IDX_W-1:0]  rd_ptr;
    logic [31:0]       line_buf [LINE_WORDS];

    logic              grant;
    logic              ret_take;
    logic [CNT_W-1:0]  issue_nxt;
    logic [CNT_W-1:0]  ret_nxt;
    logic [OUT_W-1:0]  out_nxt;

    // Next-cycle counter values; mem_req/mem_addr are registered from these so
    // the request line reflects the counts the memory will see next cycle.
    always_comb begin
        grant     = (state == ST_FETCH) && mem_req && mem_gnt;
        ret_take  = (state == ST_FETCH) && mem_rvalid && (ret_cnt < LINE_CNT);
        issue_nxt = issue_cnt + CNT_W'(grant);
        ret_nxt   = ret_cnt + CNT_W'(ret_take);
        out_nxt   = out_cnt + OUT_W'(grant) - OUT_W'(ret_take);
    end

    // Refill sequencer with registered outputs.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            out_cnt   <= '0;
            rd_ptr    <= '0;
            resp_data <= '0;
            resp_ack  <= 1'b0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (icache_ren) begin
                        base      <= icache_addr & ALIGN_MASK;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        out_cnt   <= '0;
                        rd_ptr    <= '0;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_addr  <= icache_addr & ALIGN_MASK;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    issue_cnt <= issue_nxt;
                    ret_cnt   <= ret_nxt;
                    out_cnt   <= out_nxt;
                    if (ret_nxt == LINE_CNT) begin
                        // The final word lands in the last slot this edge, so
                        // slot 0 is already stable for the first beat.
                        mem_req   <= 1'b0;
                        resp_ack  <= 1'b1;
                        resp_data <= line_buf[0];
                        rd_ptr    <= '0;
                        state     <= ST_STREAM;
                    end else begin
                        mem_req  <= (issue_nxt < LINE_CNT) && (out_nxt < OUT_MAX);
                        mem_addr <= base + ADDR_W'(issue_nxt);
                    end
                end
                ST_STREAM: begin
                    if (rd_ptr == LAST_IDX) begin
                        resp_ack  <= 1'b0;
                        resp_data <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        rd_ptr    <= rd_ptr + IDX_W'(1);
                        resp_data <= line_buf[rd_ptr + IDX_W'(1)];
                    end
                end
                ST_DRAIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line buffer: returns arrive in request order, so ret_cnt is the slot.
    always_ff @(posedge cpu_clk) begin
        if (ret_take) begin
            line_buf[ret_cnt[IDX_W-1:0]] <= mem_rdata;
        end
    end

`ifdef ICACHE_REFILL_STATS_EN
    // Saturating counters for refills started and cycles spent fetching.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_refills     <= '0;
            stat_wait_cycles <= '0;
        end else begin
            if ((state == ST_IDLE) && icache_ren && (stat_refills != '1)) begin
                stat_refills <= stat_refills + 32'd1;
            end
            if ((state == ST_FETCH) && (stat_wait_cycles != '1)) begin
                stat_wait_cycles <= stat_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_responder.sv
// Testbench for icache_refill_responder: behavioural memory with random grant
// and in-order random return latency, burst collector, and a line-level
// reference computed directly from the memory contents.
module tb_icache_refill_responder;

    localparam int LW = 16;

    logic        cpu_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        icache_ren = 1'b0;
    logic [20:0] icache_addr = '0;
    logic [31:0] resp_data;
    logic        resp_ack;
    logic        busy;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] stat_refills;
    logic [31:0] stat_wait_cycles;
`endif

    icache_refill_responder #(
        .LINE_WORDS(LW), .ADDR_W(21), .MAX_OUTSTANDING(4)
    ) dut (
        .cpu_clk(cpu_clk), .reset_n(reset_n),
        .icache_ren(icache_ren), .icache_addr(icache_addr),
        .resp_data(resp_data), .resp_ack(resp_ack), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ICACHE_REFILL_STATS_EN
        , .stat_refills(stat_refills), .stat_wait_cycles(stat_wait_cycles)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory model controls
    int          gnt_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          mode_hash = 1'b0;
    logic [31:0] salt = '0;
    bit          spur_en = 1'b0;
    bit          drain_inj = 1'b0;
    int          inj_cnt = 0;
    int          max_out = 0;
    logic [20:0] pend_addr[$];
    int          pend_due[$];
    logic [20:0] gaddr[$];
    int          last_due = 0;
    bit          prev_ack = 1'b0;

    function automatic logic [31:0] mdata(input logic [20:0] a);
        if (!mode_hash) return {11'b0, a} * 32'd4;
        return ({11'b0, a} * 32'h9E3779B1) ^ salt;
    endfunction

    // Memory: grants decided per cycle, returns delivered in order after latency.
    always @(negedge cpu_clk) begin : mem_model
        int due;
        if (!reset_n) begin
            pend_addr.delete();
            pend_due.delete();
            last_due   = 0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            prev_ack   = 1'b0;
        end else begin
            if (pend_addr.size() > max_out) max_out = pend_addr.size();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mdata(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else if (spur_en || (drain_inj && busy && !resp_ack && prev_ack)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom();
                if (!spur_en) inj_cnt++;
            end
            mem_gnt = ($urandom_range(99, 0) < gnt_pct);
            if (mem_req && mem_gnt) begin
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(mem_addr);
                pend_due.push_back(due);
                gaddr.push_back(mem_addr);
            end
            prev_ack = resp_ack;
        end
    end

    // Burst collector: words, run lengths and ack-low gaps between runs.
    logic [31:0] got[$];
    int          runs[$];
    int          gaps[$];
    int          run = 0;
    int          low = 0;
    bit          in_run = 1'b0;
    bit          have_prev = 1'b0;

    always @(negedge cpu_clk) begin
        if (resp_ack) begin
            got.push_back(resp_data);
            run++;
            if (!in_run && have_prev) gaps.push_back(low);
            in_run = 1'b1;
        end else begin
            if (in_run) begin
                runs.push_back(run);
                run = 0;
                in_run = 1'b0;
                have_prev = 1'b1;
                low = 0;
            end
            low++;
        end
    end

    task automatic clear_mon();
        @(posedge cpu_clk);
        got.delete(); runs.delete(); gaps.delete(); gaddr.delete();
        run = 0; low = 0; in_run = 1'b0; have_prev = 1'b0;
        @(negedge cpu_clk);
    endtask

    task automatic set_mem(input int pct, input int lo, input int hi, input bit hash);
        gnt_pct = pct; lat_lo = lo; lat_hi = hi; mode_hash = hash; salt = $urandom();
    endtask

    // Called at a negedge. hold = cycle count after which ren drops (0: keep
    // high until nruns bursts have completed).
    task automatic refill(input logic [20:0] a, input int hold, input int nruns, output int lat);
        int n;
        bit done;
        icache_addr = a;
        icache_ren  = 1'b1;
        lat = 0; done = 1'b0; n = 0;
        while (!done && n < 3000) begin
            @(posedge cpu_clk);
            @(negedge cpu_clk);
            n++;
            if (n == hold) icache_ren = 1'b0;
            if (resp_ack && lat == 0) lat = n;
            if (runs.size() >= nruns) done = 1'b1;
        end
        icache_ren = 1'b0;
        chk("refill_done", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge cpu_clk);
            n++;
        end
        chk("back_to_idle", 32'(busy), 32'd0);
    endtask

    task automatic verify_line(input logic [20:0] a, input int off, input string tag);
        logic [20:0] base;
        logic [31:0] obs;
        base = a & ~21'(LW - 1);
        for (int i = 0; i < LW; i++) begin
            obs = (off + i < got.size()) ? got[off + i] : 32'hDEAD_BEEF;
            chk({tag, "_data"}, obs, mdata(base + 21'(i)));
            obs = (off + i < gaddr.size()) ? 32'(gaddr[off + i]) : 32'hDEAD_BEEF;
            chk({tag, "_addr"}, obs, 32'(base + 21'(i)));
        end
    endtask

    initial begin : main
        int lat;
        int acks;
        int n;
        int nb;
        logic [20:0] a;

        // reset values
        repeat (3) @(negedge cpu_clk);
        chk("rst_ack", 32'(resp_ack), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        @(negedge cpu_clk);

        // zero-wait memory, mem[a] = a*4
        set_mem(100, 1, 1, 1'b0);
        clear_mon();
        refill(21'h00123, 1, 1, lat);
        chk("zw_latency", 32'(lat), 32'd18);
        chk("zw_run_len", 32'(runs.size() > 0 ? runs[0] : 0), 32'(LW));
        chk("zw_words", 32'(got.size()), 32'(LW));
        verify_line(21'h00123, 0, "zw");
        wait_idle();

        // random grant and return latency
        max_out = 0;
        set_mem(50, 1, 6, 1'b1);
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            a = 21'($urandom_range(21'h1FFFFF, 0));
            refill(a, int'($urandom_range(3, 1)), 1, lat);
            chk("rnd_run_len", 32'(runs.size() > 0 ? runs[0] : 0), 32'(LW));
            chk("rnd_words", 32'(got.size()), 32'(LW));
            verify_line(a, 0, "rnd");
            wait_idle();
        end
        chk("rnd_max_outstanding_le4", 32'(max_out <= 4), 32'd1);

        // ren held across completion: two back-to-back refills of the same line
        set_mem(100, 1, 1, 1'b1);
        clear_mon();
        refill(21'h0ABCD, 0, 2, lat);
        chk("keep_runs", 32'(runs.size()), 32'd2);
        chk("keep_run2_len", 32'(runs.size() > 1 ? runs[1] : 0), 32'(LW));
        chk("keep_gap", 32'(gaps.size() > 0 ? gaps[0] : 0), 32'd19);
        verify_line(21'h0ABCD, 0, "keep1");
        verify_line(21'h0ABCD, LW, "keep2");
        wait_idle();

        // ren dropped one cycle after acceptance, spurious return in DRAIN
        set_mem(50, 1, 4, 1'b1);
        inj_cnt = 0;
        drain_inj = 1'b1;
        clear_mon();
        a = 21'($urandom_range(21'h1FFFFF, 0));
        refill(a, 2, 1, lat);
        chk("drop_run_len", 32'(runs.size() > 0 ? runs[0] : 0), 32'(LW));
        verify_line(a, 0, "drop");
        wait_idle();
        drain_inj = 1'b0;
        chk("drain_inj_seen", 32'(inj_cnt), 32'd1);
        clear_mon();
        a = 21'($urandom_range(21'h1FFFFF, 0));
        refill(a, 1, 1, lat);
        verify_line(a, 0, "after_drain");
        wait_idle();

        // reset pulsed in the 5th STREAM cycle
        set_mem(100, 1, 1, 1'b1);
        clear_mon();
        icache_addr = 21'h0A5A5;
        icache_ren  = 1'b1;
        acks = 0; n = 0;
        while (acks < 5 && n < 200) begin
            @(posedge cpu_clk);
            @(negedge cpu_clk);
            n++;
            if (n == 1) icache_ren = 1'b0;
            if (resp_ack) acks++;
        end
        chk("rst_mid_reached", 32'(acks), 32'd5);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(resp_ack), 32'd0);
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_data", resp_data, 32'd0);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        reset_n = 1'b1;
        nb = got.size();
        spur_en = 1'b1;
        repeat (5) @(negedge cpu_clk);
        spur_en = 1'b0;
        @(negedge cpu_clk);
        chk("rst_no_more_ack", 32'(got.size()), 32'(nb));
        chk("rst_idle_busy", 32'(busy), 32'd0);
        chk("rst_idle_req", 32'(mem_req), 32'd0);
        clear_mon();
        refill(21'h1FFFF0, 1, 1, lat);
        chk("top_latency", 32'(lat), 32'd18);
        verify_line(21'h1FFFF0, 0, "top");
        wait_idle();

`ifdef ICACHE_REFILL_STATS_EN
        reset_n = 1'b0;
        @(negedge cpu_clk);
        reset_n = 1'b1;
        @(negedge cpu_clk);
        set_mem(100, 1, 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            refill(21'(k * 64), 1, 1, lat);
            wait_idle();
        end
        chk("stat_refills", stat_refills, 32'd3);
        chk("stat_wait_cycles", stat_wait_cycles, 32'd51);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Memory-side responder for instruction-cache line refills, clocked on cpu_clk.
- Accepts a line-fill request (icache_ren plus word address) and fetches LINE_WORDS words from a backing memory read port. Memory returns may arrive with gaps; the block buffers them.
- Replays the whole line as one gap-free burst on resp_data with resp_ack held high for exactly LINE_WORDS consecutive cycles.
- Sits between the cache refill port and the SDRAM/boot-memory read port.

Parameters:
- LINE_WORDS, 16, words per cache line; power of two, 2..64.
- ADDR_W, 21, word-address width (8 MB / 2M words).
- MAX_OUTSTANDING, 4, maximum memory reads issued but not yet returned.

Ports:
- cpu_clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- icache_ren  in  1  refill request; level, sampled only in IDLE.
- icache_addr  in  ADDR_W  word address of requested line; low log2(LINE_WORDS) bits ignored.
- resp_data  out  32  line word; valid only while resp_ack=1.
- resp_ack  out  1  high for LINE_WORDS consecutive cycles, one word per cycle.
- busy  out  1  high in any state other than IDLE.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  word address for mem_req.
- mem_gnt  in  1  request accepted on cycles where mem_req & mem_gnt.
- mem_rvalid  in  1  read data valid; returns arrive in request order.
- mem_rdata  in  32  read data.

Behaviour:
- Reset values: resp_ack=0, resp_data=0, busy=0, mem_req=0, mem_addr=0. All counters, the line buffer write pointer and the state are cleared; state=IDLE.
- Line buffer: LINE_WORDS x 32 register array, indexed by the low address bits.
- Counters:
  - issue_cnt: requests granted.
  - ret_cnt: words returned.
  - out_cnt: outstanding reads = issue_cnt - ret_cnt, kept as its own register.
- IDLE:
  - On icache_ren=1, latch base = icache_addr with the low log2(LINE_WORDS) bits forced to 0.
  - Clear the counters and go to FETCH.
- FETCH:
  - mem_req=1 while issue_cnt<LINE_WORDS and out_cnt<MAX_OUTSTANDING; mem_addr = base + issue_cnt.
  - issue_cnt increments on mem_req & mem_gnt.
  - On mem_rvalid, write mem_rdata to buf[ret_cnt] and increment ret_cnt.
  - A grant and a return in the same cycle: out_cnt is unchanged.
  - When the last word is captured (ret_cnt reaches LINE_WORDS), go to STREAM.
- STREAM:
  - resp_ack=1 and resp_data=buf[rd_ptr]; rd_ptr runs 0..LINE_WORDS-1, one per cycle.
  - After word LINE_WORDS-1, go to DRAIN.
- DRAIN: one cycle with resp_ack=0, then IDLE. This guarantees at least one ack-low cycle between lines.
- Latency:
  - icache_ren sampled high at edge N → mem_req high during cycle N+1.
  - Last return captured at edge M → first resp_ack during cycle M+1.
  - Zero-wait memory (gnt always 1, rvalid one cycle after grant): request-to-first-ack is LINE_WORDS+2 cycles.
- Boundary conditions:
  - icache_ren dropping during FETCH or STREAM is ignored; the latched line always completes.
  - icache_ren still high on return to IDLE starts a new refill of the current icache_addr.
  - mem_rvalid in IDLE, STREAM or DRAIN, or any return beyond LINE_WORDS, is discarded; this covers stale returns after reset.
  - Address wrap: base + issue_cnt wraps modulo 2^ADDR_W. It cannot cross the line because base is aligned.
  - Reset mid-operation: immediate return to reset values; the current burst is truncated and no further ack is produced.

Optional Feature:
- Macro: ICACHE_REFILL_STATS_EN.
- When defined, two extra outputs are added:
  - stat_refills (32 bit): increments on each IDLE→FETCH.
  - stat_wait_cycles (32 bit): increments each cycle in FETCH.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- When not defined, neither the ports nor the counters exist. Functional behaviour is identical either way.

Test Plan:
- Zero-wait memory (mem[a]=a*4): icache_addr=21'h00123 held 1 cycle → mem_addr sequence 0x00120..0x0012F; resp_ack high for 16 consecutive cycles with resp_data 0x480,0x484,...,0x4BC; first ack 18 cycles after ren.
- Random mem_gnt (50%) and rvalid latency 1–6: verify out_cnt never exceeds 4; resp_ack is still 16 contiguous cycles with correct ordered data.
- icache_ren kept high across completion: verify one DRAIN cycle with ack=0, then a second full refill of the same line.
- icache_ren dropped one cycle after acceptance: the full 16-word burst is still delivered. A spurious mem_rvalid injected in DRAIN is ignored, and the next line's data is unaffected.
- reset_n pulsed low at the 5th STREAM cycle: resp_ack=0 and mem_req=0 immediately; late rvalids are ignored; the next request at 21'h1FFFF0 fetches 0x1FFFF0..0x1FFFFF.
- With ICACHE_REFILL_STATS_EN: after 3 zero-wait refills, stat_refills=3 and stat_wait_cycles=51 (17 FETCH cycles per line).
